mem_byte_master: RTL and testbench
==================================

# mem_byte_master

Initiator-side load/store sequencer between the CPU memory stage and a byte-wide memory bus. It accepts one load or store request per transaction, using the CPU's `mem_u_b_h_w` size/sign encoding. It executes the request as 1, 2 or 4 little-endian byte transfers with a req/ack handshake. It returns sign- or zero-extended load data, or a store completion, as a single-cycle response.

## Interface
- `TIMEOUT`, default 16: maximum cycles to wait for `mem_ack` per byte; 0 disables the timeout.
- `clk` in 1: single clock; all state updates on posedge.
- `rstn` in 1: reset, synchronous, active-low.
- `req_valid` in 1: CPU request present.
- `req_ready` out 1: block idle and able to accept.
- `req_we` in 1: 1 = store, 0 = load.
- `req_addr` in 32: byte address of the least significant byte.
- `req_wdata` in 32: store data; the low 1/2/4 bytes are used.
- `req_size` in 3: `mem_u_b_h_w`. Bit1 = word, bit0 = half, bit2 = unsigned. Bit1 takes priority over bit0. Neither bit set = byte.
- `resp_valid` out 1: one-cycle completion pulse.
- `resp_rdata` out 32: extended load data; 0 for stores and errors.
- `resp_err` out 1: valid with `resp_valid`; 1 = timeout abort.
- `mem_req` out 1: byte transfer request.
- `mem_we` out 1: byte write enable.
- `mem_addr` out 32: byte address.
- `mem_wdata` out 8: write byte.
- `mem_ack` in 1: byte transfer complete in this cycle; ignored while `mem_req` = 0.
- `mem_rdata` in 8: read byte, valid in the `mem_ack` cycle.

## Operation
- States: IDLE, XFER, RESP.
- IDLE
  - `req_ready` = 1.
  - On `req_valid`, latch `req_addr`, `req_wdata`, `req_we` and `req_size`.
  - Set nbytes = 4 (bit1), else 2 (bit0), else 1. Clear idx, the wait counter and the read buffer. Go to XFER.
- XFER
  - Drive `mem_req` = 1 and `mem_we` = latched we.
  - `mem_addr` = base + idx, computed mod 2^32 (wraps 0xFFFFFFFF to 0x00000000).
  - `mem_wdata` = wdata[8*idx+7 : 8*idx].
  - On `mem_ack`: for a load, store `mem_rdata` into buffer byte idx. Clear the wait counter. If idx == nbytes-1, go to RESP; otherwise increment idx.
  - `mem_req` stays high across byte boundaries; the next address and data appear in the cycle after the ack.
- Timeout
  - With `TIMEOUT` > 0, the wait counter increments on each XFER cycle without ack.
  - If `TIMEOUT` consecutive cycles pass without ack, drop `mem_req` and go to RESP with the error flag set.
  - Bytes already written stay written; there is no rollback.
  - An ack arriving in the same cycle the count reaches `TIMEOUT` counts as success.
- RESP
  - `resp_valid` = 1 for exactly one cycle, then return to IDLE.
  - `resp_err` = error flag.
  - Load without error: `resp_rdata` = buffer extended from bit 7 (byte) or bit 15 (half). The extension is sign, or zero if bit2 is set. A word returns the buffer as-is.
  - Store or error: `resp_rdata` = 0.
- `req_ready` = 0 in XFER and RESP. `req_valid` in those states is not latched, and the CPU must hold it.
- Inputs `req_*` are sampled only in the accept cycle; later changes have no effect.

## Timing
- Reset (`rstn` = 0 at posedge)
  - State IDLE. `mem_req`, `mem_we`, `resp_valid` and `resp_err` = 0. `mem_addr`, `mem_wdata` and `resp_rdata` = 0. idx and wait counter = 0.
  - `req_ready` = 1 from the first cycle after release.
- Reset mid-XFER: `mem_req` drops on that same edge with no response, and the partial transfer is abandoned.
- Zero-wait memory (ack in every `mem_req` cycle), n bytes:
  - Accept at cycle 0.
  - Byte transfers in cycles 1..n.
  - `resp_valid` in cycle n+1.
  - Next accept possible at cycle n+2.
- Each wait cycle adds one cycle to the transfer.
- Timeout response: RESP in the cycle after the `TIMEOUT`-th ack-less cycle.
- All outputs are registered or decoded from registered state only; there is no combinational path from `mem_ack` to `mem_*` outputs.

## Test plan
- Signed byte load, addr 0x20, memory 0x80:
  - One `mem_req` cycle at 0x20.
  - `resp_rdata` = 0xFFFFFF80 with `resp_valid` at cycle 2.
  - With `req_size` = 3'b100, `resp_rdata` = 0x00000080.
- Unsigned half load, addr 0x31, bytes 0x34, 0xF2:
  - Addresses 0x31 then 0x32.
  - `resp_rdata` = 0x0000F234.
  - Signed variant gives 0xFFFFF234.
- Word store 0x12345678 at 0x10:
  - Bytes 0x78, 0x56, 0x34, 0x12 at 0x10..0x13, with `mem_we` = 1.
  - `resp_valid` at cycle 5 with `resp_rdata` = 0 and `resp_err` = 0.
  - `req_size` = 3'b011 behaves identically (word).
- Word load at 0xFFFFFFFE with 2 wait cycles on byte 1:
  - Addresses 0xFFFFFFFE, 0xFFFFFFFF, 0x0, 0x1.
  - `mem_addr` holds 0xFFFFFFFF for 3 cycles.
  - Response at cycle 7.
- `TIMEOUT` = 4, ack withheld on byte 0 of a half store:
  - `mem_req` high for 4 cycles, then low.
  - `resp_valid` = 1, `resp_err` = 1, `resp_rdata` = 0.
  - `req_ready` returns the cycle after.
- `rstn` low during byte 2 of a word load:
  - Next cycle `mem_req` = 0, no `resp_valid`, `req_ready` = 1 after release.
  - A fresh byte load completes normally.

Source files
------------

// File: rtl/mem_byte_master_if.sv
// Bundle of the CPU request/response and byte-bus signals around mem_byte_master.
// master = the sequencer itself, slave = the CPU/memory environment driving it.
interface mem_byte_master_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [2:0]  req_size;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        mem_ack;
    logic [7:0]  mem_rdata;

    modport master (
        input  req_valid, req_we, req_addr, req_wdata, req_size, mem_ack, mem_rdata,
        output req_ready, resp_valid, resp_rdata, resp_err, mem_req, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        output req_valid, req_we, req_addr, req_wdata, req_size, mem_ack, mem_rdata,
        input  req_ready, resp_valid, resp_rdata, resp_err, mem_req, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_byte_master.sv
// Load/store sequencer: splits a CPU byte/half/word access into little-endian
// byte transfers on a req/ack bus and returns one extended response pulse.
module mem_byte_master #(
    parameter int TIMEOUT = 16
) (
    input  logic               clk,
    input  logic               rstn,
    mem_byte_master_if.master  bus,
    output logic [1:0]         dbg_state
);
    // Handshakes: a request transfers when req_valid && req_ready at a posedge; a
    // byte transfers when mem_req && mem_ack at a posedge; resp_valid is a
    // one-cycle pulse with no back-pressure.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

    state_t      state, state_d;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] rbuf_q;
    logic        we_q;
    logic [2:0]  size_q;
    logic [1:0]  idx_q;
    logic [1:0]  last_q;
    logic [CW-1:0] wait_q;
    logic        err_q;
    logic        last_byte;
    logic        timed_out;
    logic        sext;
    logic [31:0] ext_data;

    assign last_byte = (idx_q == last_q);
    // An ack in the final allowed cycle wins over the timeout.
    assign timed_out = (TIMEOUT != 0) && !bus.mem_ack && (wait_q == CW'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (!rstn) state <= IDLE;
        else       state <= state_d;
    end

    always_comb begin
        state_d = state;
        unique case (state)
            IDLE: if (bus.req_valid) state_d = XFER;
            XFER: if ((bus.mem_ack && last_byte) || timed_out) state_d = RESP;
            RESP: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            addr_q  <= '0;
            wdata_q <= '0;
            rbuf_q  <= '0;
            we_q    <= 1'b0;
            size_q  <= '0;
            idx_q   <= '0;
            last_q  <= '0;
            wait_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.req_valid) begin
                        addr_q  <= bus.req_addr;
                        wdata_q <= bus.req_wdata;
                        we_q    <= bus.req_we;
                        size_q  <= bus.req_size;
                        last_q  <= bus.req_size[1] ? 2'd3 : (bus.req_size[0] ? 2'd1 : 2'd0);
                        idx_q   <= '0;
                        wait_q  <= '0;
                        rbuf_q  <= '0;
                        err_q   <= 1'b0;
                    end
                end
                XFER: begin
                    if (bus.mem_ack) begin
                        if (!we_q) rbuf_q[{idx_q, 3'b000} +: 8] <= bus.mem_rdata;
                        wait_q <= '0;
                        if (!last_byte) idx_q <= idx_q + 2'd1;
                    end else if (timed_out) begin
                        err_q <= 1'b1;
                    end else if (TIMEOUT != 0) begin
                        wait_q <= wait_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        sext = !size_q[2];
        if (size_q[1])      ext_data = rbuf_q;
        else if (size_q[0]) ext_data = {{16{sext & rbuf_q[15]}}, rbuf_q[15:0]};
        else                ext_data = {{24{sext & rbuf_q[7]}}, rbuf_q[7:0]};
    end

    assign bus.req_ready  = (state == IDLE);
    assign bus.mem_req    = (state == XFER);
    assign bus.mem_we     = (state == XFER) && we_q;
    assign bus.mem_addr   = (state == XFER) ? (addr_q + {30'd0, idx_q}) : 32'd0;
    assign bus.mem_wdata  = (state == XFER) ? wdata_q[{idx_q, 3'b000} +: 8] : 8'd0;
    assign bus.resp_valid = (state == RESP);
    assign bus.resp_err   = (state == RESP) && err_q;
    assign bus.resp_rdata = (state == RESP && !we_q && !err_q) ? ext_data : 32'd0;
    assign dbg_state      = state;
endmodule

// File: tb/tb_mem_byte_master.sv
// Randomized bench for mem_byte_master: a byte-array memory model answers the bus
// and a scoreboard predicts each response from the access rules.
module tb_mem_byte_master;
    localparam int TO = 4;

    logic       clk;
    logic       rstn;
    logic [1:0] dbg_state;
    int         n_tests;
    int         n_fail;

    logic [31:0] exp_q[$];
    logic [7:0]  mem_model [logic [31:0]];

    mem_byte_master_if bus();

    mem_byte_master #(.TIMEOUT(TO)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .bus       (bus.master),
        .dbg_state (dbg_state)
    );

    // clock / watchdog
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] mem_rd(input logic [31:0] a);
        if (mem_model.exists(a)) return mem_model[a];
        return a[7:0] ^ 8'h5A;
    endfunction

    function automatic int nbytes(input logic [2:0] sz);
        return sz[1] ? 4 : (sz[0] ? 2 : 1);
    endfunction

    // Plain arithmetic: little-endian sum of bytes, then signed range shift.
    function automatic logic [31:0] load_value(input logic [31:0] a, input logic [2:0] sz);
        longint v;
        int n;
        n = nbytes(sz);
        v = 0;
        for (int i = 0; i < n; i++) v += longint'(mem_rd(a + 32'(i))) << (8 * i);
        if (!sz[2] && n == 1 && v >= 128)   v -= 256;
        if (!sz[2] && n == 2 && v >= 32768) v -= 65536;
        return v[31:0];
    endfunction

    // driver: one full transaction; waits holds a 4-bit wait count per byte,
    // to_byte names a byte whose ack is withheld forever (-1 = none)
    task automatic txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [2:0] size, input logic [15:0] waits, input int to_byte,
                       output logic [31:0] got, output int cyc_o, output int reqc_o);
        int n, k, w, cyc, reqc, exp_cyc, exp_reqc;
        logic exp_err, done, stop;
        logic [3:0] wn;
        logic [31:0] exp_rd, wd;
        n = nbytes(size);
        exp_err = (to_byte >= 0) && (to_byte < n);
        exp_cyc = 1;
        exp_reqc = 0;
        stop = 1'b0;
        for (int i = 0; i < n; i++) begin
            if (!stop) begin
                if (exp_err && i == to_byte) begin
                    exp_cyc += TO;
                    exp_reqc += TO;
                    stop = 1'b1;
                end else begin
                    exp_cyc += int'(waits[i*4 +: 4]) + 1;
                    exp_reqc += int'(waits[i*4 +: 4]) + 1;
                end
            end
        end
        exp_rd = (we || exp_err) ? 32'd0 : load_value(addr, size);
        exp_q.push_back(exp_rd);
        wd = wdata;

        @(negedge clk);
        check("ready_before", 32'(bus.req_ready), 32'd1);
        bus.req_valid = 1'b1;
        bus.req_we    = we;
        bus.req_addr  = addr;
        bus.req_wdata = wdata;
        bus.req_size  = size;
        @(posedge clk);
        cyc = 0; k = 0; w = 0; reqc = 0; done = 1'b0; got = 32'd0;
        while (!done && cyc < 80) begin
            @(negedge clk);
            cyc++;
            bus.req_valid = 1'(($urandom & 1));
            bus.req_we    = 1'(($urandom & 1));
            bus.req_addr  = $urandom;
            bus.req_wdata = $urandom;
            bus.req_size  = 3'($urandom_range(0, 7));
            bus.mem_ack   = 1'b0;
            bus.mem_rdata = 8'($urandom);
            if (bus.resp_valid) begin
                done = 1'b1;
                got = bus.resp_rdata;
                check("resp_cycle", 32'(cyc), 32'(exp_cyc));
                check("resp_err", 32'(bus.resp_err), 32'(exp_err));
                check("resp_rdata", bus.resp_rdata, exp_q.pop_front());
                check("mem_req_cycles", 32'(reqc), 32'(exp_reqc));
                check("mem_req_in_resp", 32'(bus.mem_req), 32'd0);
            end else if (bus.mem_req) begin
                reqc++;
                check("mem_addr", bus.mem_addr, addr + 32'(k));
                check("mem_we", 32'(bus.mem_we), 32'(we));
                if (we && k < 4) check("mem_wdata", 32'(bus.mem_wdata), 32'(wd[k*8 +: 8]));
                wn = (k < 4) ? waits[k*4 +: 4] : 4'd0;
                if (k == to_byte || w < int'(wn)) begin
                    w++;
                end else begin
                    bus.mem_ack = 1'b1;
                    if (we) mem_model[addr + 32'(k)] = bus.mem_wdata;
                    else    bus.mem_rdata = mem_rd(addr + 32'(k));
                    k++;
                    w = 0;
                end
            end
        end
        if (!done) begin
            check("resp_seen", 32'd0, 32'd1);
            void'(exp_q.pop_front());
        end
        @(negedge clk);
        bus.req_valid = 1'b0;
        check("resp_one_cycle", 32'(bus.resp_valid), 32'd0);
        check("ready_after", 32'(bus.req_ready), 32'd1);
        cyc_o = cyc;
        reqc_o = reqc;
    endtask

    initial begin
        logic [31:0] got, a, wd;
        logic [2:0]  sz;
        logic [15:0] wt;
        int cyc, reqc, tb_byte;
        logic we;
        n_tests = 0;
        n_fail = 0;
        rstn = 1'b0;
        bus.req_valid = 1'b0;
        bus.req_we    = 1'b0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        bus.req_size  = '0;
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = '0;

        // reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_mem_req", 32'(bus.mem_req), 32'd0);
        check("rst_mem_we", 32'(bus.mem_we), 32'd0);
        check("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
        check("rst_resp_err", 32'(bus.resp_err), 32'd0);
        check("rst_mem_addr", bus.mem_addr, 32'd0);
        check("rst_mem_wdata", 32'(bus.mem_wdata), 32'd0);
        check("rst_resp_rdata", bus.resp_rdata, 32'd0);
        rstn = 1'b1;
        @(negedge clk);
        check("rst_ready", 32'(bus.req_ready), 32'd1);

        // signed / unsigned byte load
        mem_model[32'h20] = 8'h80;
        txn(1'b0, 32'h20, 32'h0, 3'b000, 16'h0, -1, got, cyc, reqc);
        check("lb_value", got, 32'hFFFFFF80);
        check("lb_cycle", 32'(cyc), 32'd2);
        check("lb_reqs", 32'(reqc), 32'd1);
        txn(1'b0, 32'h20, 32'h0, 3'b100, 16'h0, -1, got, cyc, reqc);
        check("lbu_value", got, 32'h00000080);

        // half loads
        mem_model[32'h31] = 8'h34;
        mem_model[32'h32] = 8'hF2;
        txn(1'b0, 32'h31, 32'h0, 3'b101, 16'h0, -1, got, cyc, reqc);
        check("lhu_value", got, 32'h0000F234);
        txn(1'b0, 32'h31, 32'h0, 3'b001, 16'h0, -1, got, cyc, reqc);
        check("lh_value", got, 32'hFFFFF234);

        // word stores (size 010 and 011) read back as words
        txn(1'b1, 32'h10, 32'h12345678, 3'b010, 16'h0, -1, got, cyc, reqc);
        check("sw_rdata", got, 32'd0);
        check("sw_cycle", 32'(cyc), 32'd5);
        txn(1'b1, 32'h18, 32'h12345678, 3'b011, 16'h0, -1, got, cyc, reqc);
        check("sw11_cycle", 32'(cyc), 32'd5);
        txn(1'b0, 32'h10, 32'h0, 3'b010, 16'h0, -1, got, cyc, reqc);
        check("lw_back", got, 32'h12345678);
        txn(1'b0, 32'h18, 32'h0, 3'b011, 16'h0, -1, got, cyc, reqc);
        check("lw11_back", got, 32'h12345678);

        // wrapping word load, 2 waits on byte 1
        txn(1'b0, 32'hFFFFFFFE, 32'h0, 3'b010, 16'h0020, -1, got, cyc, reqc);
        check("wrap_cycle", 32'(cyc), 32'd7);

        // timeout on byte 0 of a half store
        txn(1'b1, 32'h50, 32'hBEEF, 3'b001, 16'h0, 0, got, cyc, reqc);
        check("to_rdata", got, 32'd0);
        check("to_cycle", 32'(cyc), 32'd5);
        check("to_reqs", 32'(reqc), 32'd4);

        // timeout on byte 2 of a word load, and maximum legal waits
        txn(1'b0, 32'h60, 32'h0, 3'b010, 16'h0012, 2, got, cyc, reqc);
        txn(1'b0, 32'h70, 32'h0, 3'b010, 16'h3333, -1, got, cyc, reqc);
        check("maxwait_cycle", 32'(cyc), 32'd17);

        // reset during byte 2 of a word load
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b0;
        bus.req_addr  = 32'h40;
        bus.req_size  = 3'b010;
        @(posedge clk);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            bus.req_valid = 1'b0;
            check("rst_mid_req", 32'(bus.mem_req), 32'd1);
            check("rst_mid_addr", bus.mem_addr, 32'h40 + 32'(i));
            bus.mem_ack = (i < 2);
            bus.mem_rdata = 8'($urandom);
            if (i == 2) rstn = 1'b0;
        end
        @(negedge clk);
        bus.mem_ack = 1'b0;
        check("rst_mid_mem_req", 32'(bus.mem_req), 32'd0);
        check("rst_mid_resp", 32'(bus.resp_valid), 32'd0);
        rstn = 1'b1;
        @(negedge clk);
        check("rst_mid_ready", 32'(bus.req_ready), 32'd1);
        check("rst_mid_resp2", 32'(bus.resp_valid), 32'd0);
        txn(1'b0, 32'h20, 32'h0, 3'b000, 16'h0, -1, got, cyc, reqc);
        check("post_rst_lb", got, 32'hFFFFFF80);

        // randomized traffic
        for (int t = 0; t < 40; t++) begin
            we = 1'(($urandom & 1));
            sz = 3'($urandom_range(0, 7));
            a  = ($urandom_range(0, 3) == 0) ? (32'hFFFFFFFC + 32'($urandom_range(0, 3)))
                                             : (32'h100 + 32'($urandom_range(0, 63)));
            wd = $urandom;
            wt = '0;
            for (int b = 0; b < 4; b++) wt[b*4 +: 4] = 4'($urandom_range(0, TO - 1));
            tb_byte = ($urandom_range(0, 7) == 0) ? $urandom_range(0, nbytes(sz) - 1) : -1;
            txn(we, a, wd, sz, wt, tb_byte, got, cyc, reqc);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
